// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package cpu_pkg;

    // Tag destinations are held zero-extended to a fixed width so one struct serves any ADDRESSWIDTH up to 8.
    localparam int TAG_DEST_W = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic                  valid;
        logic [TAG_DEST_W-1:0] dest;
        logic                  isLoad;
    } reg_tag_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    function automatic logic tag_hit(input reg_tag_t t, input logic [TAG_DEST_W-1:0] addr);
        return t.valid && (t.dest == addr);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - D/E stage hazard request and stall/flush response bundle
interface pipeline_hazard_ctrl_if #(
    parameter int REGNUM       = 16,
    parameter int ADDRESSWIDTH = 4,
    parameter int CNTWIDTH     = 16
);
    logic                    validD;
    logic                    writesRegD;
    logic                    isLoadD;
    logic                    usesReg1D;
    logic                    usesReg2D;
    logic [ADDRESSWIDTH-1:0] regDestinationAddressD;
    logic [ADDRESSWIDTH-1:0] reg1AddressD;
    logic [ADDRESSWIDTH-1:0] reg2AddressD;
    logic                    branchTakenE;
    logic                    stallF;
    logic                    stallD;
    logic                    flushD;
    logic                    bubbleE;
    logic [REGNUM-1:0]       busyRegs;
    logic [CNTWIDTH-1:0]     stallCount;
    logic [CNTWIDTH-1:0]     flushCount;
`ifdef PIPELINE_FORWARDING_EN
    logic [1:0]              forwardSel1;
    logic [1:0]              forwardSel2;
`endif

    modport master (
        output validD, writesRegD, isLoadD, usesReg1D, usesReg2D,
        output regDestinationAddressD, reg1AddressD, reg2AddressD, branchTakenE,
`ifdef PIPELINE_FORWARDING_EN
        input  forwardSel1, forwardSel2,
`endif
        input  stallF, stallD, flushD, bubbleE, busyRegs, stallCount, flushCount
    );

    modport slave (
        input  validD, writesRegD, isLoadD, usesReg1D, usesReg2D,
        input  regDestinationAddressD, reg1AddressD, reg2AddressD, branchTakenE,
`ifdef PIPELINE_FORWARDING_EN
        output forwardSel1, forwardSel2,
`endif
        output stallF, stallD, flushD, bubbleE, busyRegs, stallCount, flushCount
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// rtl/pipeline_hazard_ctrl_sat_counter.sv - saturating up-counter used for stall/flush statistics
module sat_counter #(
    parameter int CNTWIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    output logic [CNTWIDTH-1:0] count
);

    logic [CNTWIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RAW stall / branch flush controller for the 5-stage pipeline
// Optional load-use-only stalling with operand forwarding under PIPELINE_FORWARDING_EN.
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REGNUM       = 16,
    parameter int ADDRESSWIDTH = 4,
    parameter int CNTWIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);

    reg_tag_t      r_tagE;
    reg_tag_t      r_tagM;
    reg_tag_t      r_tagW;
    hazard_state_t r_state;
    hazard_state_t w_next;
    logic          r_live;

    logic [TAG_DEST_W-1:0] w_src1;
    logic [TAG_DEST_W-1:0] w_src2;
    logic [TAG_DEST_W-1:0] w_dst;
    logic                  w_rd1;
    logic                  w_rd2;
    logic                  w_hitE;
    logic                  w_hitM;
    logic                  w_hazard;
    logic                  w_stall;
    logic                  w_flush;
    logic [REGNUM-1:0]     w_busy;
    logic [CNTWIDTH-1:0]   w_stall_cnt;
    logic [CNTWIDTH-1:0]   w_flush_cnt;
    logic                  w_unused_ok;

    assign w_src1 = TAG_DEST_W'(bus.reg1AddressD);
    assign w_src2 = TAG_DEST_W'(bus.reg2AddressD);
    assign w_dst  = TAG_DEST_W'(bus.regDestinationAddressD);
    assign w_rd1  = bus.validD & bus.usesReg1D;
    assign w_rd2  = bus.validD & bus.usesReg2D;

    assign w_hitE = (w_rd1 & tag_hit(r_tagE, w_src1)) | (w_rd2 & tag_hit(r_tagE, w_src2));
    assign w_hitM = (w_rd1 & tag_hit(r_tagM, w_src1)) | (w_rd2 & tag_hit(r_tagM, w_src2));

`ifdef PIPELINE_FORWARDING_EN
    logic [1:0] w_fwd1;
    logic [1:0] w_fwd2;

    // Only a load still in E cannot be forwarded; its data appears in M one cycle later.
    assign w_hazard = w_hitE & r_tagE.isLoad;

    // Selection is for the cycle the D instruction enters E, when the E producer has moved to M.
    always_comb begin
        w_fwd1 = FWD_RF;
        w_fwd2 = FWD_RF;
        if (w_rd1 && tag_hit(r_tagE, w_src1)) begin
            w_fwd1 = FWD_M;
        end else if (w_rd1 && tag_hit(r_tagM, w_src1)) begin
            w_fwd1 = FWD_W;
        end
        if (w_rd2 && tag_hit(r_tagE, w_src2)) begin
            w_fwd2 = FWD_M;
        end else if (w_rd2 && tag_hit(r_tagM, w_src2)) begin
            w_fwd2 = FWD_W;
        end
    end

    assign bus.forwardSel1 = r_live ? w_fwd1 : FWD_RF;
    assign bus.forwardSel2 = r_live ? w_fwd2 : FWD_RF;
`else
    logic w_hitW;

    // W is a hazard too: the register file does not bypass a same-cycle write.
    assign w_hitW   = (w_rd1 & tag_hit(r_tagW, w_src1)) | (w_rd2 & tag_hit(r_tagW, w_src2));
    assign w_hazard = w_hitE | w_hitM | w_hitW;
`endif

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_flush = 1'b0;
        case (r_state)
            STALL: begin
                if (w_hazard) begin
                    w_stall = 1'b1;
                end else begin
                    w_next = RUN;
                end
            end
            default: begin
                if (bus.branchTakenE) begin
                    w_flush = 1'b1;
                    w_next  = FLUSH;
                end else if (w_hazard) begin
                    w_stall = 1'b1;
                    w_next  = STALL;
                end else begin
                    w_next = RUN;
                end
            end
        endcase
        // Outputs stay quiet until one clock edge after reset release.
        if (!r_live) begin
            w_stall = 1'b0;
            w_flush = 1'b0;
            w_next  = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tagE <= '0;
            r_tagM <= '0;
            r_tagW <= '0;
        end else begin
            r_tagW <= r_tagM;
            r_tagM <= r_tagE;
            if (bus.validD && bus.writesRegD && !w_stall && !w_flush) begin
                r_tagE <= '{valid: 1'b1, dest: w_dst, isLoad: bus.isLoadD};
            end else begin
                r_tagE <= '0;
            end
        end
    end

    always_comb begin
        w_busy = '0;
        for (int r = 0; r < REGNUM; r++) begin
            w_busy[r] = tag_hit(r_tagE, TAG_DEST_W'(r)) |
                        tag_hit(r_tagM, TAG_DEST_W'(r)) |
                        tag_hit(r_tagW, TAG_DEST_W'(r));
        end
    end

    sat_counter #(.CNTWIDTH(CNTWIDTH)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall),
        .count (w_stall_cnt)
    );

    sat_counter #(.CNTWIDTH(CNTWIDTH)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_flush),
        .count (w_flush_cnt)
    );

    assign bus.stallF     = w_stall;
    assign bus.stallD     = w_stall;
    assign bus.flushD     = w_flush;
    assign bus.bubbleE    = w_stall | w_flush;
    assign bus.busyRegs   = w_busy;
    assign bus.stallCount = w_stall_cnt;
    assign bus.flushCount = w_flush_cnt;

    assign w_unused_ok = r_tagW.isLoad;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int RN = 16;
    localparam int AW = 4;
    localparam int CW = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    pipeline_hazard_ctrl_if #(.REGNUM(RN), .ADDRESSWIDTH(AW), .CNTWIDTH(CW)) bus ();

    pipeline_hazard_ctrl #(.REGNUM(RN), .ADDRESSWIDTH(AW), .CNTWIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_d();
        bus.validD                 = 1'b0;
        bus.writesRegD             = 1'b0;
        bus.isLoadD                = 1'b0;
        bus.usesReg1D              = 1'b0;
        bus.usesReg2D              = 1'b0;
        bus.regDestinationAddressD = '0;
        bus.reg1AddressD           = '0;
        bus.reg2AddressD           = '0;
    endtask

    task automatic set_d(input logic wr, input logic ld, input logic u1, input logic u2,
                         input logic [AW-1:0] dst, input logic [AW-1:0] s1, input logic [AW-1:0] s2);
        bus.validD                 = 1'b1;
        bus.writesRegD             = wr;
        bus.isLoadD                = ld;
        bus.usesReg1D              = u1;
        bus.usesReg2D              = u2;
        bus.regDestinationAddressD = dst;
        bus.reg1AddressD           = s1;
        bus.reg2AddressD           = s2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        clear_d();
        bus.branchTakenE = 1'b1;

        // In reset with a branch request: everything must stay quiet.
        #3;
        chk("rst_flushD",  32'(bus.flushD), 32'd0);
        chk("rst_bubbleE", 32'(bus.bubbleE), 32'd0);
        chk("rst_stallD",  32'(bus.stallD), 32'd0);
        chk("rst_busy",    32'(bus.busyRegs), 32'd0);
        chk("rst_scnt",    32'(bus.stallCount), 32'd0);
        chk("rst_fcnt",    32'(bus.flushCount), 32'd0);

        tick();
        reset = 1'b1;
        #3;
        chk("first_cycle_flushD", 32'(bus.flushD), 32'd0);
        tick();
        bus.branchTakenE = 1'b0;

`ifndef PIPELINE_FORWARDING_EN
        // Independent ops: ADD R1,R2,R3 then ADD R4,R5,R6.
        set_d(1, 0, 1, 1, 4'd1, 4'd2, 4'd3);
        #3;
        chk("ind_a_stallD", 32'(bus.stallD), 32'd0);
        chk("ind_a_busy",   32'(bus.busyRegs), 32'h0000);
        tick();
        set_d(1, 0, 1, 1, 4'd4, 4'd5, 4'd6);
        #3;
        chk("ind_b_stallD", 32'(bus.stallD), 32'd0);
        chk("ind_b_busy",   32'(bus.busyRegs), 32'h0002);
        tick();
        clear_d();
        #3;
        chk("ind_c2_busy", 32'(bus.busyRegs), 32'h0012);
        tick();
        #3;
        chk("ind_c3_busy", 32'(bus.busyRegs), 32'h0012);
        tick();
        #3;
        chk("ind_c4_busy", 32'(bus.busyRegs), 32'h0010);
        tick();
        #3;
        chk("ind_c5_busy", 32'(bus.busyRegs), 32'h0000);

        // Back-to-back RAW: SUB R0,R15,R15 then ADD R1,R0,R0 stalls for E, M and W.
        tick();
        set_d(1, 0, 1, 1, 4'd0, 4'd15, 4'd15);
        #3;
        chk("raw_sub_stallD", 32'(bus.stallD), 32'd0);
        tick();
        set_d(1, 0, 1, 1, 4'd1, 4'd0, 4'd0);
        #3;
        chk("raw_s1_stallD",  32'(bus.stallD), 32'd1);
        chk("raw_s1_stallF",  32'(bus.stallF), 32'd1);
        chk("raw_s1_bubbleE", 32'(bus.bubbleE), 32'd1);
        chk("raw_s1_busy",    32'(bus.busyRegs), 32'h0001);
        tick();
        #3;
        chk("raw_s2_stallD", 32'(bus.stallD), 32'd1);
        tick();
        #3;
        chk("raw_s3_stallD", 32'(bus.stallD), 32'd1);
        chk("raw_s3_busy",   32'(bus.busyRegs), 32'h0001);
        tick();
        #3;
        chk("raw_issue_stallD",  32'(bus.stallD), 32'd0);
        chk("raw_issue_bubbleE", 32'(bus.bubbleE), 32'd0);
        chk("raw_scnt",          32'(bus.stallCount), 32'd3);
        tick();
        clear_d();
        #3;
        chk("raw_add_busy", 32'(bus.busyRegs), 32'h0002);

        // Taken branch for one cycle.
        tick();
        bus.branchTakenE = 1'b1;
        #3;
        chk("br_flushD",  32'(bus.flushD), 32'd1);
        chk("br_bubbleE", 32'(bus.bubbleE), 32'd1);
        chk("br_stallD",  32'(bus.stallD), 32'd0);
        chk("br_fcnt0",   32'(bus.flushCount), 32'd0);
        tick();
        bus.branchTakenE = 1'b0;
        #3;
        chk("br_fl_flushD",  32'(bus.flushD), 32'd0);
        chk("br_fl_bubbleE", 32'(bus.bubbleE), 32'd0);
        chk("br_fcnt1",      32'(bus.flushCount), 32'd1);

        // Branch and hazard together: flush wins; then a hazard seen in FLUSH stalls.
        tick();
        set_d(1, 0, 0, 0, 4'd5, 4'd0, 4'd0);
        #3;
        chk("bh_prod_stallD", 32'(bus.stallD), 32'd0);
        tick();
        set_d(1, 0, 1, 0, 4'd6, 4'd5, 4'd0);
        bus.branchTakenE = 1'b1;
        #3;
        chk("bh_flushD",  32'(bus.flushD), 32'd1);
        chk("bh_stallD",  32'(bus.stallD), 32'd0);
        chk("bh_stallF",  32'(bus.stallF), 32'd0);
        chk("bh_bubbleE", 32'(bus.bubbleE), 32'd1);
        tick();
        bus.branchTakenE = 1'b0;
        #3;
        chk("bh_fl_stallD", 32'(bus.stallD), 32'd1);
        chk("bh_fl_flushD", 32'(bus.flushD), 32'd0);
        chk("bh_scnt",      32'(bus.stallCount), 32'd3);
        chk("bh_fcnt",      32'(bus.flushCount), 32'd2);
        chk("bh_busy",      32'(bus.busyRegs), 32'h0020);
        tick();
        #3;
        chk("bh_w_stallD", 32'(bus.stallD), 32'd1);
        tick();
        #3;
        chk("bh_issue_stallD", 32'(bus.stallD), 32'd0);
        chk("bh_issue_scnt",   32'(bus.stallCount), 32'd5);

        // Continuous branches saturate the 4-bit flush counter at 15.
        tick();
        clear_d();
        bus.branchTakenE = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        #3;
        chk("sat_flushD", 32'(bus.flushD), 32'd1);
        chk("sat_fcnt",   32'(bus.flushCount), 32'd15);
        tick();
        #3;
        chk("sat_fcnt_hold", 32'(bus.flushCount), 32'd15);
        bus.branchTakenE = 1'b0;
`else
        // ALU RAW on R0 forwards from M without stalling.
        set_d(1, 0, 1, 1, 4'd0, 4'd15, 4'd15);
        tick();
        set_d(1, 0, 1, 1, 4'd1, 4'd0, 4'd0);
        #3;
        chk("fwd_alu_stallD", 32'(bus.stallD), 32'd0);
        chk("fwd_alu_sel1",   32'(bus.forwardSel1), 32'd1);
        chk("fwd_alu_sel2",   32'(bus.forwardSel2), 32'd1);
        tick();
        clear_d();
        tick();
        // Load R2 then use R2: one stall, then forward from W.
        set_d(1, 1, 0, 0, 4'd2, 4'd0, 4'd0);
        tick();
        set_d(1, 0, 1, 0, 4'd3, 4'd2, 4'd0);
        #3;
        chk("fwd_ld_stallD", 32'(bus.stallD), 32'd1);
        tick();
        #3;
        chk("fwd_ld_issue_stallD", 32'(bus.stallD), 32'd0);
        chk("fwd_ld_sel1",         32'(bus.forwardSel1), 32'd2);
        chk("fwd_ld_scnt",         32'(bus.stallCount), 32'd1);
        tick();
        clear_d();
`endif

        // Reset asserted while stalling on a load-use of R7.
        tick();
        clear_d();
        tick();
        tick();
        tick();
        set_d(1, 1, 0, 0, 4'd7, 4'd0, 4'd0);
        tick();
        set_d(1, 0, 1, 0, 4'd8, 4'd7, 4'd0);
        #3;
        chk("mid_pre_stallD", 32'(bus.stallD), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_stallF", 32'(bus.stallF), 32'd0);
        chk("mid_stallD", 32'(bus.stallD), 32'd0);
        chk("mid_busy",   32'(bus.busyRegs), 32'h0000);
        chk("mid_scnt",   32'(bus.stallCount), 32'd0);
        chk("mid_fcnt",   32'(bus.flushCount), 32'd0);
        #1;
        reset = 1'b1;
        tick();
        bus.branchTakenE = 1'b1;
        #3;
        chk("post_rst_stallD", 32'(bus.stallD), 32'd0);
        chk("post_rst_flushD", 32'(bus.flushD), 32'd1);
        tick();
        bus.branchTakenE = 1'b0;
        clear_d();
        #3;
        chk("post_rst_fcnt", 32'(bus.flushCount), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
